ysyx_25010008_mc_ctrl: RTL
==========================

# ysyx_25010008_mc_ctrl

Multi-cycle sequencer for the next-generation NPC core. It replaces single-cycle PC stepping. It owns the PC, the instruction register and the load-data register. It fetches through a valid/ready instruction port and sequences decode/execute, optional load/store and writeback as separate states. Register and CSR write enables leave it as one-cycle pulses. It sits in the NPC top between the IFU/LSU bus ports and the IDU/EXU/register-file datapath.

## Interface
Parameters:
- XLEN, 32, PC / data width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, max cycles in any bus request/wait state (only with macro)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  fetch request accepted
- ifu_addr  out  XLEN  fetch address, equals pc
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_data  in  32  fetched instruction
- inst  out  32  latched instruction to IDU
- pc  out  XLEN  current PC to EXU
- dec_r_wen, dec_csr_wen1, dec_csr_wen2  in  1 each  IDU write requests (level)
- dec_mem_ren, dec_mem_wen  in  1 each  IDU memory access requests
- dec_halt  in  1  IDU ebreak/halt decode
- exu_npc  in  XLEN  next PC from EXU
- lsu_req_valid  out  1  data request
- lsu_req_wen  out  1  1 = store, 0 = load
- lsu_req_ready  in  1  data request accepted
- lsu_rsp_valid  in  1  data response valid
- lsu_rsp_data  in  XLEN  load data
- mem_rdata  out  XLEN  latched load data to EXU writeback mux
- r_wen, csr_wen1, csr_wen2  out  1 each  gated write pulses
- retire  out  1  one-cycle pulse per completed instruction
- halt  out  1  sticky halted flag
- bus_err  out  1  sticky timeout flag

## Operation
- States: IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset values:
  - State: IF_REQ.
  - Registers: pc=RESET_PC; inst=32'h0000_0013 (nop); mem_rdata=0.
  - Outputs: all pulses/valids 0; halt=0; bus_err=0.
- IF_REQ:
  - ifu_req_valid=1.
  - ifu_req_ready=1 moves to IF_WAIT.
- IF_WAIT:
  - ifu_rsp_valid=1 latches inst and moves to EXEC.
  - The response may arrive in the same cycle ifu_req_ready rises. It is then ignored; the controller waits for the next ifu_rsp_valid.
- EXEC:
  - One cycle for IDU/EXU to settle.
  - dec_halt=1 moves to HALT.
  - Else dec_mem_ren|dec_mem_wen moves to MEM_REQ.
  - Else moves to WB.
  - dec_halt has priority over memory flags.
- MEM_REQ:
  - lsu_req_valid=1.
  - lsu_req_wen=dec_mem_wen.
  - lsu_req_ready=1 moves to MEM_WAIT.
- MEM_WAIT:
  - lsu_rsp_valid=1 moves to WB.
  - On a load, lsu_rsp_data is also latched into mem_rdata.
  - On a store, mem_rdata is unchanged.
- WB:
  - r_wen=dec_r_wen, csr_wen1=dec_csr_wen1, csr_wen2=dec_csr_wen2, retire=1.
  - pc<=exu_npc, then moves to IF_REQ.
- HALT: absorbing; halt=1 until rst. No requests are issued and no write pulses occur.
- inst and pc are stable from EXEC through WB. IDU/EXU outputs are sampled only in EXEC, MEM_REQ and WB.
- r_wen/csr_wen* are 0 in every state other than WB.
- Valids are held until accepted; the address is stable while valid=1.
- Reset mid-operation: state and registers clear immediately. Bus slaves share rst, so no stale response survives.

## Timing
- Zero-wait bus (ready with valid, response next cycle):
  - Non-memory instruction: 4 cycles.
  - Load/store: 6 cycles.
- retire is 1 exactly in the WB cycle; the new pc is visible the next cycle.
- Each cycle ready or rsp is held low adds one cycle in the corresponding state.
- Halt asserts in the cycle after EXEC.

## Configuration
- YSYX_25010008_BUS_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to IF_REQ/IF_WAIT/MEM_REQ/MEM_WAIT and increments each cycle in those states.
  - When the count reaches TIMEOUT, the controller moves to HALT with bus_err=1 and halt=1 (both sticky).
- Not defined: counter absent; bus_err tied 0; waits are unbounded.

## Test plan
- Reset then zero-wait fetch of addi -> ifu_addr=0x8000_0000; r_wen pulse in cycle 4; pc=0x8000_0004 in cycle 5; retire once.
- Load with lsu_rsp_data=0xDEAD_BEEF, 3-cycle lsu_req_ready delay -> mem_rdata=0xDEAD_BEEF; r_wen in WB; total 9 cycles.
- Store (dec_mem_wen=1, dec_r_wen=0) -> lsu_req_wen=1 and held with valid until ready; no r_wen pulse; mem_rdata unchanged.
- dec_halt=1 together with dec_mem_ren=1 -> no lsu_req_valid; halt=1 sticky; retire=0; further ifu_req_ready toggling is ignored.
- rst asserted asynchronously in MEM_WAIT -> same-cycle clear: pc=0x8000_0000, lsu_req_valid=0, halt=0.
- With macro, TIMEOUT=15, ifu_req_ready held 0 -> bus_err=1 and halt=1 after 15 cycles in IF_REQ. Without macro -> stays in IF_REQ indefinitely.

Source files
------------

// File: rtl/ysyx_25010008_mc_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_mc_ctrl
//
// Multi-cycle instruction sequencer for the NPC core. It owns the PC, the
// instruction register and the load-data register. Each instruction runs
// through this sequence:
//   IF_REQ -> IF_WAIT -> EXEC -> [MEM_REQ -> MEM_WAIT] -> WB -> IF_REQ
// Decode/execute results are consumed as levels while the FSM sits in
// EXEC, MEM_REQ and WB. Register-file and CSR write enables leave the
// block only as one-cycle pulses in WB.
//
// Optional feature: define YSYX_25010008_BUS_TIMEOUT_EN to bound every bus
// request/wait state by TIMEOUT cycles. When the bound expires, the
// controller parks in HALT with a sticky bus_err. Without the macro,
// bus_err is tied low and bus waits are unbounded.
// ---------------------------------------------------------------------------
module ysyx_25010008_mc_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,

    // instruction fetch port
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_addr,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_data,

    // datapath view of the current instruction
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,

    // decode / execute results (levels, valid from EXEC onward)
    input  logic            dec_r_wen,
    input  logic            dec_csr_wen1,
    input  logic            dec_csr_wen2,
    input  logic            dec_mem_ren,
    input  logic            dec_mem_wen,
    input  logic            dec_halt,
    input  logic [XLEN-1:0] exu_npc,

    // load/store port
    output logic            lsu_req_valid,
    output logic            lsu_req_wen,
    input  logic            lsu_req_ready,
    input  logic            lsu_rsp_valid,
    input  logic [XLEN-1:0] lsu_rsp_data,
    output logic [XLEN-1:0] mem_rdata,

    // gated write pulses and status
    output logic            r_wen,
    output logic            csr_wen1,
    output logic            csr_wen2,
    output logic            retire,
    output logic            halt,
    output logic            bus_err
);

    typedef enum logic [2:0] {
        IF_REQ   = 3'd0,
        IF_WAIT  = 3'd1,
        EXEC     = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
    // Remembers whether the accepted data request was a store, so MEM_WAIT
    // knows whether to capture the response without re-reading the decoder.
    logic              store_q, store_d;

    // A state in which the controller waits on a bus handshake.
    logic              in_bus_state;
    assign in_bus_state = (state_q == IF_REQ)  || (state_q == IF_WAIT) ||
                          (state_q == MEM_REQ) || (state_q == MEM_WAIT);

`ifdef YSYX_25010008_BUS_TIMEOUT_EN
    // The counter is at least 8 bits wide and always wide enough to hold TIMEOUT.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout_hit;

    // The current cycle is the TIMEOUT-th cycle spent in this bus state.
    assign timeout_hit = in_bus_state && (cnt_q >= CW'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // State register. Reset is asynchronous because the bus slaves share rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A completed handshake always wins over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_REQ:   if (ifu_req_ready) state_d = IF_WAIT;
            // A response that arrives in the same cycle as the request
            // handshake is seen while still in IF_REQ, so it is ignored.
            IF_WAIT:  if (ifu_rsp_valid) state_d = EXEC;
            EXEC: begin
                if (dec_halt) begin
                    state_d = HALT;
                end else if (dec_mem_ren || dec_mem_wen) begin
                    state_d = MEM_REQ;
                end else begin
                    state_d = WB;
                end
            end
            MEM_REQ:  if (lsu_req_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (lsu_rsp_valid) state_d = WB;
            WB:       state_d = IF_REQ;
            HALT:     state_d = HALT;
            default:  state_d = IF_REQ;
        endcase
`ifdef YSYX_25010008_BUS_TIMEOUT_EN
        if (timeout_hit && (state_d == state_q)) begin
            state_d = HALT;
        end
`endif
    end

    // Outputs as functions of state. Valids are held low while rst is
    // asserted, so the reset state is quiet on both bus ports.
    always_comb begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        r_wen         = 1'b0;
        csr_wen1      = 1'b0;
        csr_wen2      = 1'b0;
        retire        = 1'b0;
        case (state_q)
            IF_REQ: begin
                ifu_req_valid = !rst;
            end
            MEM_REQ: begin
                lsu_req_valid = !rst;
                lsu_req_wen   = dec_mem_wen;
            end
            WB: begin
                r_wen    = dec_r_wen;
                csr_wen1 = dec_csr_wen1;
                csr_wen2 = dec_csr_wen2;
                retire   = 1'b1;
            end
            default: begin
                ifu_req_valid = 1'b0;
            end
        endcase
    end

    // Next values for the architectural registers held by the sequencer.
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        mem_rdata_d = mem_rdata_q;
        store_d     = store_q;
        if ((state_q == IF_WAIT) && ifu_rsp_valid) begin
            inst_d = ifu_rsp_data;
        end
        if ((state_q == MEM_REQ) && lsu_req_ready) begin
            store_d = dec_mem_wen;
        end
        // Stores leave the load-data register untouched.
        if ((state_q == MEM_WAIT) && lsu_rsp_valid && !store_q) begin
            mem_rdata_d = lsu_rsp_data;
        end
        if (state_q == WB) begin
            pc_d = exu_npc;
        end
    end

    // Register update for PC, instruction, load data and the access type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            mem_rdata_q <= '0;
            store_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            mem_rdata_q <= mem_rdata_d;
            store_q     <= store_d;
        end
    end

`ifdef YSYX_25010008_BUS_TIMEOUT_EN
    // Watchdog count. It restarts on every state change and runs only in bus states.
    always_comb begin
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        if (in_bus_state && (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (timeout_hit && (state_d == HALT)) begin
            bus_err_d = 1'b1;
        end
    end

    // Watchdog registers. bus_err stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign halt      = (state_q == HALT);
    assign pc        = pc_q;
    assign ifu_addr  = pc_q;
    assign inst      = inst_q;
    assign mem_rdata = mem_rdata_q;

endmodule
